lcd_timing_generator: RTL and testbench

Downstream consumer of `fifo_32`. It drains 32-bit pixel words from the FIFO read port and generates the LCD panel timing: hsync, vsync, data-enable and 24-bit RGB. It runs entirely in the LCD pixel clock domain, which is the FIFO's output clock. The FIFO absorbs the rate difference from the write side.

---
 rtl/lcd_timing_generator.sv | 193 +++++++++++++++++++
 tb/tb_lcd_timing_generator.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_timing_generator.sv
// LCD panel timing generator. Walks an (h, v) raster position, pops one
// FIFO word per active pixel and emits hsync/vsync/de/RGB aligned to the
// popped data through a three-stage pipeline in the pixel clock domain.
module lcd_timing_generator #(
  parameter int H_ACTIVE = 480,
  parameter int H_FRONT  = 2,
  parameter int H_SYNC   = 41,
  parameter int H_BACK   = 2,
  parameter int V_ACTIVE = 272,
  parameter int V_FRONT  = 2,
  parameter int V_SYNC   = 10,
  parameter int V_BACK   = 2
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic [31:0] i_fifoData,
  input  logic        i_fifoEmpty,
  output logic        o_fifoRead,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_de,
  output logic [7:0]  o_red,
  output logic [7:0]  o_green,
  output logic [7:0]  o_blue,
  output logic        o_frameStart,
  output logic        o_underflow
);

  // Region boundaries, 12 bits wide so a 2048-clock total still compares correctly.
  localparam logic [11:0] H_ACT_C  = 12'(H_ACTIVE);
  localparam logic [11:0] H_SS_C   = 12'(H_ACTIVE + H_FRONT);
  localparam logic [11:0] H_SE_C   = 12'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [11:0] H_LAST_C = 12'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [11:0] V_ACT_C  = 12'(V_ACTIVE);
  localparam logic [11:0] V_SS_C   = 12'(V_ACTIVE + V_FRONT);
  localparam logic [11:0] V_SE_C   = 12'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [11:0] V_LAST_C = 12'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);

  logic [10:0] h_q, h_d, v_q, v_d;
  // The first enabled clock after reset only arms the raster, so position
  // (0,0) enters stage 1 one clock later and all latencies count from there.
  logic        started_q;
  logic        run_s;
  logic        h_act_s, v_act_s, h_sync_s, v_sync_s, pix_act_s;

  // Stage 1 registers and their next values
  logic        rd_q, rd_d;
  logic        s1_de_q, s1_de_d;
  logic        s1_hs_q, s1_hs_d;
  logic        s1_vs_q, s1_vs_d;
  logic        s1_fs_q, s1_fs_d;
  logic        s1_starved_q, s1_starved_d;
  logic        underflow_q;

  // Stage 2 registers
  logic        s2_de_q, s2_hs_q, s2_vs_q, s2_fs_q, s2_starved_q;

  // Stage 3 (output) registers
  logic        de_q, hs_q, vs_q, fs_q;
  logic [23:0] rgb_q, rgb_d;

  // Padding byte of the pixel word carries no colour information.
  logic [7:0]  unused_pad_s;
  assign unused_pad_s = i_fifoData[31:24];

  assign run_s     = i_enable & started_q;
  assign h_act_s   = {1'b0, h_q} < H_ACT_C;
  assign v_act_s   = {1'b0, v_q} < V_ACT_C;
  assign h_sync_s  = ({1'b0, h_q} >= H_SS_C) && ({1'b0, h_q} < H_SE_C);
  assign v_sync_s  = ({1'b0, v_q} >= V_SS_C) && ({1'b0, v_q} < V_SE_C);
  assign pix_act_s = h_act_s & v_act_s;

  // Raster counter next state: h wraps into a v increment, both wrap to (0,0).
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (run_s) begin
      if ({1'b0, h_q} == H_LAST_C) begin
        h_d = 11'd0;
        if ({1'b0, v_q} == V_LAST_C) begin
          v_d = 11'd0;
        end else begin
          v_d = v_q + 11'd1;
        end
      end else begin
        h_d = h_q + 11'd1;
      end
    end else begin
      h_d = h_q;
      v_d = v_q;
    end
  end

  // Raster position and arm flag registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      h_q       <= 11'd0;
      v_q       <= 11'd0;
      started_q <= 1'b0;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      started_q <= started_q | i_enable;
    end
  end

  // Stage 1 decode: pop request, starvation and timing flags of the current
  // position; syncs follow the (possibly frozen) position even when idle.
  always_comb begin
    rd_d         = pix_act_s & ~i_fifoEmpty & run_s;
    s1_starved_d = pix_act_s &  i_fifoEmpty & run_s;
    s1_de_d      = pix_act_s & run_s;
    s1_fs_d      = run_s & (h_q == 11'd0) & (v_q == 11'd0);
    s1_hs_d      = ~h_sync_s;
    s1_vs_d      = ~v_sync_s;
  end

  // Stage 1 registers, including the sticky underflow flag.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rd_q         <= 1'b0;
      s1_de_q      <= 1'b0;
      s1_hs_q      <= 1'b1;
      s1_vs_q      <= 1'b1;
      s1_fs_q      <= 1'b0;
      s1_starved_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      rd_q         <= rd_d;
      s1_de_q      <= s1_de_d;
      s1_hs_q      <= s1_hs_d;
      s1_vs_q      <= s1_vs_d;
      s1_fs_q      <= s1_fs_d;
      s1_starved_q <= s1_starved_d;
      underflow_q  <= underflow_q | s1_starved_d;
    end
  end

  // Stage 2 delay so timing lines up with the word the FIFO presents after a pop.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      s2_de_q      <= 1'b0;
      s2_hs_q      <= 1'b1;
      s2_vs_q      <= 1'b1;
      s2_fs_q      <= 1'b0;
      s2_starved_q <= 1'b0;
    end else begin
      s2_de_q      <= s1_de_q;
      s2_hs_q      <= s1_hs_q;
      s2_vs_q      <= s1_vs_q;
      s2_fs_q      <= s1_fs_q;
      s2_starved_q <= s1_starved_q;
    end
  end

  // Colour is blanked outside active video and for starved pixels.
  always_comb begin
    if (s2_de_q && !s2_starved_q) begin
      rgb_d = i_fifoData[23:0];
    end else begin
      rgb_d = 24'd0;
    end
  end

  // Stage 3 output registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      de_q  <= 1'b0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      fs_q  <= 1'b0;
      rgb_q <= 24'd0;
    end else begin
      de_q  <= s2_de_q;
      hs_q  <= s2_hs_q;
      vs_q  <= s2_vs_q;
      fs_q  <= s2_fs_q;
      rgb_q <= rgb_d;
    end
  end

  assign o_fifoRead   = rd_q;
  assign o_hsync      = hs_q;
  assign o_vsync      = vs_q;
  assign o_de         = de_q;
  assign o_red        = rgb_q[23:16];
  assign o_green      = rgb_q[15:8];
  assign o_blue       = rgb_q[7:0];
  assign o_frameStart = fs_q;
  assign o_underflow  = underflow_q;

endmodule

// File: tb/tb_lcd_timing_generator.sv
// Self-checking bench for lcd_timing_generator on a small 8x6 raster.
// A reference model tracks a linear raster position with plain arithmetic
// and predicts every output on every clock.
module tb_lcd_timing_generator;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] fifo_data;
  logic        empty;
  logic        o_fifoRead, o_hsync, o_vsync, o_de, o_frameStart, o_underflow;
  logic [7:0]  o_red, o_green, o_blue;

  always #5 clk = ~clk;

  lcd_timing_generator #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_enable    (en),
    .i_fifoData  (fifo_data),
    .i_fifoEmpty (empty),
    .o_fifoRead  (o_fifoRead),
    .o_hsync     (o_hsync),
    .o_vsync     (o_vsync),
    .o_de        (o_de),
    .o_red       (o_red),
    .o_green     (o_green),
    .o_blue      (o_blue),
    .o_frameStart(o_frameStart),
    .o_underflow (o_underflow)
  );

  int checks = 0;
  int errors = 0;

  // Every comparison goes through here.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: what each raster position should produce.
  typedef struct {
    bit          pop;
    bit          de;
    bit          hs;
    bit          vs;
    bit          fs;
    logic [23:0] rgb;
  } ev_t;

  localparam ev_t IDLE = '{pop: 1'b0, de: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, rgb: 24'd0};

  ev_t ev0, ev1, ev2;   // ev0 = just entered the pipeline, ev2 = now on the outputs
  int  m_pos;           // linear raster index h + v*HT
  bit  m_started;
  bit  m_uf;
  int  m_widx;          // value of the next word the FIFO will hand out
  int  fifo_n;          // bench FIFO: next word number

  task automatic model_reset();
    if (ev0.pop) m_widx--;   // a strobe cut by reset never reaches the FIFO
    m_pos     = 0;
    m_started = 1'b0;
    m_uf      = 1'b0;
    ev0       = IDLE;
    ev1       = IDLE;
    ev2       = IDLE;
  endtask

  task automatic model_edge();
    ev_t e;
    int  h, v;
    bit  act;
    h    = m_pos % HT;
    v    = m_pos / HT;
    e    = IDLE;
    e.hs = !(h >= HA + HF && h < HA + HF + HS);
    e.vs = !(v >= VA + VF && v < VA + VF + VS);
    if (en && m_started) begin
      act  = (h < HA) && (v < VA);
      e.de = act;
      e.fs = (m_pos == 0);
      if (act && !empty) begin
        e.pop = 1'b1;
        e.rgb = 24'(m_widx);
        m_widx++;
      end
      if (act && empty) m_uf = 1'b1;
      m_pos = (m_pos + 1) % FT;
    end
    if (en) m_started = 1'b1;
    ev2 = ev1;
    ev1 = ev0;
    ev0 = e;
  endtask

  task automatic compare_all();
    check("fifoRead",   o_fifoRead, ev0.pop);
    check("de",         o_de, ev2.de);
    check("hsync",      o_hsync, ev2.hs);
    check("vsync",      o_vsync, ev2.vs);
    check("frameStart", o_frameStart, ev2.fs);
    check("rgb",        {o_red, o_green, o_blue}, ev2.rgb);
    check("underflow",  o_underflow, m_uf);
  endtask

  // One clock: FIFO sees the strobe at the edge and presents the word after it.
  task automatic step();
    logic rd_b;
    rd_b = o_fifoRead;
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    if (rd_b) begin
      fifo_data = {8'hC3, 24'(fifo_n)};
      fifo_n++;
    end
    compare_all();
  endtask

  // Asynchronous reset pulse in the middle of a clock period.
  task automatic async_reset();
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    step();
    step();
    rst = 1'b0;
  endtask

  int pops, hs_low, vs_low, fs_cnt;
  int fs_edge[2];

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    empty     = 1'b0;
    fifo_data = 32'd0;
    fifo_n    = 1;
    m_widx    = 1;
    model_reset();

    // Reset values while reset is held.
    #2;
    compare_all();
    step();
    rst = 1'b0;

    // Reset released with enable low: nothing moves.
    for (int i = 0; i < 10; i++) step();

    // Pixel stream and sync timing; edge 0 is the first enabled edge.
    en      = 1'b1;
    pops    = 0;
    hs_low  = 0;
    vs_low  = 0;
    fs_cnt  = 0;
    fs_edge[0] = -1;
    fs_edge[1] = -1;
    for (int e = 0; e <= 60; e++) begin
      step();
      if (e >= 1 && e <= 48 && o_fifoRead) pops++;
      if (e >= 3 && e <= 50 && !o_hsync) hs_low++;
      if (e >= 3 && e <= 50 && !o_vsync) vs_low++;
      if (o_frameStart && fs_cnt < 2) begin
        fs_edge[fs_cnt] = e;
        fs_cnt++;
      end
    end
    check("pops_per_frame", pops, HA * VA);
    check("hsync_low_clocks", hs_low, HS * VT);
    check("vsync_low_clocks", vs_low, VS * HT);
    check("frameStart_edge_a", fs_edge[0], 3);
    check("frameStart_edge_b", fs_edge[1], 3 + FT);

    // Underflow on the clock that would produce the second pop.
    async_reset();
    step();              // edge 0
    step();              // edge 1: first pop
    empty = 1'b1;
    step();              // edge 2: starved
    empty = 1'b0;
    for (int i = 0; i < 2 * FT; i++) step();
    check("underflow_sticky", o_underflow, 1'b1);

    // Reset mid-line during active pixels, then restart.
    for (int i = 0; i < 5; i++) step();
    while (!(ev2.de && ev1.de)) step();
    async_reset();
    for (int i = 0; i < FT + 4; i++) step();

    // Enable pause at h=2.
    while (m_pos % HT != 2 || (m_pos / HT) >= VA) step();
    en = 1'b0;
    for (int i = 0; i < 5; i++) step();
    en = 1'b1;
    for (int i = 0; i < FT; i++) step();

    // Randomized enable, empty and occasional asynchronous reset.
    for (int i = 0; i < 1500; i++) begin
      en    = ($urandom_range(0, 9) != 0);
      empty = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 249) == 0) begin
        async_reset();
      end else begin
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
